// File: rtl/add_sub_acc_if.sv
// add_sub_acc_if: request/response bundle between a requester and add_sub_acc.
//   master: drives in_valid/in_op/in_data and out_ready; observes everything else.
//   slave : drives in_ready, out_valid and the accumulator/status outputs.
interface add_sub_acc_if #(parameter int CNT_W = 8);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [3:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       acc;
    logic             carry;
    logic             ovf;
    logic             zero;
    logic [CNT_W-1:0] op_count;
    modport master(output in_valid, in_op, in_data, out_ready,
                   input in_ready, out_valid, acc, carry, ovf, zero, op_count);
    modport slave(input in_valid, in_op, in_data, out_ready,
                  output in_ready, out_valid, acc, carry, ovf, zero, op_count);
endinterface

// File: rtl/add_sub_acc.sv
// add_sub_acc: sequencing accumulator that feeds and consumes an external add_sub adder.
//   clk, rst         : clock, synchronous active-high reset
//   bus (slave)      : request handshake (in_*), response handshake (out_*), acc/flags/op_count
//   as_a/as_b/as_cin : registered operands to the adder
//   as_sum/as_cout   : adder result, captured at the end of EXEC
module add_sub_acc #(parameter int CNT_W = 8) (
    input  logic         clk,
    input  logic         rst,
    add_sub_acc_if.slave bus,
    output logic [3:0]   as_a,
    output logic [3:0]   as_b,
    output logic         as_cin,
    input  logic [3:0]   as_sum,
    input  logic         as_cout
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t           state_q;
    logic [1:0]       op_q;
    logic [3:0]       a_q, b_q, acc_q;
    logic             cin_q, carry_q, ovf_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       b_eff;
    logic             ovf_d;
    // Overflow is judged on the operand the adder really sees (b inverted for SUB).
    assign b_eff = b_q ^ {4{cin_q}};
    assign ovf_d = (a_q[3] == b_eff[3]) & (as_sum[3] != a_q[3]);
    assign cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    op_q    <= bus.in_op;
                    a_q     <= acc_q;
                    b_q     <= bus.in_data;
                    cin_q   <= bus.in_op == 2'b01;
                    state_q <= EXEC;
                end
                EXEC: begin
                    state_q <= RESP;
                    case (op_q)
                        2'b00, 2'b01: begin
                            acc_q   <= as_sum;
                            carry_q <= as_cout;
                            ovf_q   <= ovf_d;
                            cnt_q   <= cnt_d;
                        end
                        2'b10: begin
                            acc_q   <= b_q;
                            carry_q <= 1'b0;
                            ovf_q   <= 1'b0;
                        end
                        default: begin
                            acc_q   <= '0;
                            carry_q <= 1'b0;
                            ovf_q   <= 1'b0;
                            cnt_q   <= '0;
                        end
                    endcase
                end
                RESP: if (bus.out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign as_a          = a_q;
    assign as_b          = b_q;
    assign as_cin        = cin_q;
    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == RESP;
    assign bus.acc       = acc_q;
    assign bus.carry     = carry_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = acc_q == 4'd0;
    assign bus.op_count  = cnt_q;
endmodule
